// File: rtl/ring_position_monitor.sv
// Watches an asynchronous 8-bit one-hot ring counter output. The monitor resynchronises
// and debounces it, checks the stepping order, counts revolutions and drives one
// active-low 7-segment digit.
module ring_position_monitor #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned SETTLE      = 3,
    parameter int unsigned REV_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       ring,
    input  logic             err_clr,
    output logic [2:0]       pos,
    output logic             pos_valid,
    output logic             step_pulse,
    output logic             rev_pulse,
    output logic [REV_W-1:0] rev_count,
    output logic             seq_err,
    output logic [6:0]       seg
);

    localparam int unsigned CntW      = $clog2(SETTLE + 1);
    localparam logic [CntW-1:0] SettleCnt = CntW'(SETTLE);
    localparam logic [6:0] SegDash    = 7'b0111111;

    typedef enum logic [1:0] {StInit, StTrack, StFault} state_e;

    // Synchroniser chain. The valid bits track which stages hold real samples, so the
    // zeros that reset leaves in the chain can never be accepted.
    logic [7:0]             sync_q [SYNC_STAGES];
    logic [7:0]             sync_d [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] sync_vld_q, sync_vld_d;
    logic [7:0]             sync_out;
    logic                   sync_out_vld;

    // Stability filter
    logic [7:0]      cand_q, cand_d;
    logic            cand_vld_q, cand_vld_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      last_q, last_d;
    logic            acc_vld_q, acc_vld_d;
    logic            accept;

    // Tracker state and registered outputs
    state_e           state_q, state_d;
    logic [2:0]       pos_q, pos_d;
    logic             pos_valid_q, pos_valid_d;
    logic             step_q, step_d;
    logic             rev_q, rev_d;
    logic [REV_W-1:0] rev_count_q, rev_count_d;
    logic             seq_err_q, seq_err_d;
    logic [6:0]       seg_q, seg_d;

    logic       cand_onehot;
    logic [2:0] cand_idx;

    function automatic logic [6:0] digit(input logic [2:0] p);
        logic [6:0] s;
        unique case (p)
            3'd0: s = 7'b1000000;
            3'd1: s = 7'b1111001;
            3'd2: s = 7'b0100100;
            3'd3: s = 7'b0110000;
            3'd4: s = 7'b0011001;
            3'd5: s = 7'b0010010;
            3'd6: s = 7'b0000010;
            default: s = 7'b1111000;
        endcase
        return s;
    endfunction

    // Shift the ring vector and its valid marker through the synchroniser
    always_comb begin
        sync_d[0] = ring;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        sync_vld_d = {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
    end

    assign sync_out     = sync_q[SYNC_STAGES-1];
    assign sync_out_vld = sync_vld_q[SYNC_STAGES-1];

    // Restart the stability count whenever the synchronised value changes
    always_comb begin
        cand_d     = cand_q;
        cand_vld_d = cand_vld_q;
        cnt_d      = cnt_q;
        if (sync_out_vld) begin
            if (!cand_vld_q || (sync_out != cand_q)) begin
                cand_d     = sync_out;
                cand_vld_d = 1'b1;
                cnt_d      = CntW'(1);
            end else if (cnt_q != SettleCnt) begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    // A settled value is taken once; the first one after reset is always taken
    assign accept = cand_vld_q && (cnt_q == SettleCnt) && (!acc_vld_q || (cand_q != last_q));

    // One-hot check and index encoding of the candidate value
    always_comb begin
        cand_onehot = (cand_q != 8'd0) && ((cand_q & (cand_q - 8'd1)) == 8'd0);
        cand_idx    = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (cand_q[i]) cand_idx = 3'(i);
        end
    end

    // Next-state and output decode, acting only on acceptance
    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        pos_valid_d = pos_valid_q;
        step_d      = 1'b0;
        rev_d       = 1'b0;
        rev_count_d = rev_count_q;
        seq_err_d   = err_clr ? 1'b0 : seq_err_q;
        last_d      = last_q;
        acc_vld_d   = acc_vld_q;
        if (accept) begin
            last_d    = cand_q;
            acc_vld_d = 1'b1;
            if (!cand_onehot) begin
                state_d     = StFault;
                pos_valid_d = 1'b0;
                seq_err_d   = 1'b1;
            end else begin
                pos_d       = cand_idx;
                pos_valid_d = 1'b1;
                unique case (state_q)
                    StTrack: begin
                        if (cand_idx == pos_q + 3'd1) begin
                            step_d = 1'b1;
                            if (cand_idx == 3'd0) begin
                                rev_d       = 1'b1;
                                rev_count_d = rev_count_q + REV_W'(1);
                            end
                        end else begin
                            seq_err_d = 1'b1;
                        end
                    end
                    default: state_d = StTrack;
                endcase
            end
        end
        seg_d = pos_valid_d ? digit(pos_d) : SegDash;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 8'd0;
            sync_vld_q  <= '0;
            cand_q      <= 8'd0;
            cand_vld_q  <= 1'b0;
            cnt_q       <= '0;
            last_q      <= 8'd0;
            acc_vld_q   <= 1'b0;
            state_q     <= StInit;
            pos_q       <= 3'd0;
            pos_valid_q <= 1'b0;
            step_q      <= 1'b0;
            rev_q       <= 1'b0;
            rev_count_q <= '0;
            seq_err_q   <= 1'b0;
            seg_q       <= SegDash;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
            sync_vld_q  <= sync_vld_d;
            cand_q      <= cand_d;
            cand_vld_q  <= cand_vld_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            acc_vld_q   <= acc_vld_d;
            state_q     <= state_d;
            pos_q       <= pos_d;
            pos_valid_q <= pos_valid_d;
            step_q      <= step_d;
            rev_q       <= rev_d;
            rev_count_q <= rev_count_d;
            seq_err_q   <= seq_err_d;
            seg_q       <= seg_d;
        end
    end

    assign pos        = pos_q;
    assign pos_valid  = pos_valid_q;
    assign step_pulse = step_q;
    assign rev_pulse  = rev_q;
    assign rev_count  = rev_count_q;
    assign seq_err    = seq_err_q;
    assign seg        = seg_q;

endmodule
